// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_ctrl_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_SKID = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_slot.sv
// IF/ID output register plus a one-entry skid buffer for decode stalls.
module fetch_slot
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               skid_load,
  input  logic               promote,
  input  logic               flush,
  input  logic               consume,
  input  logic [INSTR_W-1:0] data_in,
  input  logic [ADDR_W-1:0]  pc4_in,
  output logic               slot_valid,
  output logic [INSTR_W-1:0] slot_instr,
  output logic [ADDR_W-1:0]  slot_pc4,
  output logic               skid_valid
);

  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc4;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid <= 1'b0;
      slot_instr <= '0;
      slot_pc4   <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc4   <= '0;
    end else if (flush) begin
      slot_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load) begin
      slot_valid <= 1'b1;
      slot_instr <= data_in;
      slot_pc4   <= pc4_in;
    end else if (skid_load) begin
      // slot still holds the stalled instruction; park the new one beside it
      skid_valid <= 1'b1;
      skid_instr <= data_in;
      skid_pc4   <= pc4_in;
    end else if (promote) begin
      slot_valid <= 1'b1;
      slot_instr <= skid_instr;
      slot_pc4   <= skid_pc4;
      skid_valid <= 1'b0;
    end else if (consume) begin
      slot_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC, req/ack memory port, IF/ID slot with skid.
// Optional FETCH_PERF_EN adds fetched/squashed saturating counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               stall,
  output logic               im_req,
  output logic [ADDR_W-1:0]  im_addr,
  input  logic               im_ack,
  input  logic [INSTR_W-1:0] im_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_squashed
`endif
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_inc;
  logic              ack;
  logic              accept;
  logic              slot_load;
  logic              skid_load;
  logic              promote;
  logic              flush;
  logic              consume;
  logic              skid_valid;

  assign im_addr = pc;
  assign pc_inc  = pc + ADDR_W'(4);
  assign ack     = im_ack && im_req;
  assign accept  = !if_valid || !stall;

  always_comb begin
    slot_load = 1'b0;
    skid_load = 1'b0;
    promote   = 1'b0;
    flush     = 1'b0;
    consume   = 1'b0;
    unique case (state)
      S_REQ: begin
        if (redirect_valid) flush = 1'b1;
        else if (ack) begin
          if (accept) slot_load = 1'b1;
          else        skid_load = 1'b1;
        end else if (accept) consume = 1'b1;
      end
      S_SKID: begin
        if (redirect_valid) flush = 1'b1;
        else if (!stall)    promote = 1'b1;
      end
      S_DROP: begin
        if (redirect_valid) flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_REQ;
      pc     <= RESET_PC;
      target <= '0;
      im_req <= 1'b1;
    end else begin
      unique case (state)
        S_REQ: begin
          if (redirect_valid) begin
            if (ack) pc <= redirect_pc;
            else begin
              target <= redirect_pc;
              state  <= S_DROP;
            end
          end else if (ack) begin
            pc <= pc_inc;
            if (!accept) begin
              state  <= S_SKID;
              im_req <= 1'b0;
            end
          end
        end
        S_SKID: begin
          if (redirect_valid) pc <= redirect_pc;
          if (redirect_valid || !stall) begin
            state  <= S_REQ;
            im_req <= 1'b1;
          end
        end
        S_DROP: begin
          // the address must stay put until the stale response arrives
          if (ack) begin
            pc    <= redirect_valid ? redirect_pc : target;
            state <= S_REQ;
          end else if (redirect_valid) begin
            target <= redirect_pc;
          end
        end
        default: begin
          state  <= S_REQ;
          im_req <= 1'b1;
        end
      endcase
    end
  end

  fetch_slot #(.ADDR_W(ADDR_W)) u_slot (
    .clk        (clk),
    .reset      (reset),
    .load       (slot_load),
    .skid_load  (skid_load),
    .promote    (promote),
    .flush      (flush),
    .consume    (consume),
    .data_in    (im_rdata),
    .pc4_in     (pc_inc),
    .slot_valid (if_valid),
    .slot_instr (if_instr),
    .slot_pc4   (if_pc4),
    .skid_valid (skid_valid)
  );

`ifdef FETCH_PERF_EN
  logic        drop_ack;
  logic [1:0]  sq_inc;
  logic [32:0] sq_sum;

  assign drop_ack = ack && ((state == S_DROP) || (state == S_REQ && redirect_valid));
  assign sq_inc   = (flush ? ({1'b0, if_valid} + {1'b0, skid_valid}) : 2'd0)
                  + {1'b0, drop_ack};
  assign sq_sum   = {1'b0, perf_squashed} + {31'd0, sq_inc};

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      if ((slot_load || promote) && perf_fetched != '1)
        perf_fetched <= perf_fetched + 32'd1;
      perf_squashed <= sq_sum[32] ? '1 : sq_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl against a queue-based fetch model.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  localparam int N_CYCLES = 4000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_squashed;
`endif

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_ack         (im_ack),
    .im_rdata       (im_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc4         (if_pc4)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_squashed  (perf_squashed)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: slot, a buffered-instruction queue, and a pending discard.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  logic [31:0] m_pc;
  logic        m_discard;
  logic [31:0] m_target;
  logic        m_slot_v;
  entry_t      m_slot;
  entry_t      m_buf[$];
  logic        m_known;
  logic        m_fresh;
  longint      m_fetched;
  longint      m_squashed;

  function automatic logic exp_req();
    return m_buf.size() == 0;
  endfunction

  task automatic model_step(input logic rst, input logic rv, input logic [31:0] rpc,
                            input logic st, input logic ack_in, input logic [31:0] rdata);
    logic ack;
    logic take;
    ack  = ack_in && exp_req();
    take = !m_slot_v || !st;
    m_fresh = 1'b0;
    if (rst) begin
      m_pc = RESET_PC_DEFAULT; m_discard = 1'b0; m_target = '0;
      m_slot_v = 1'b0; m_slot = '0; m_buf.delete();
      m_known = 1'b1; m_fresh = 1'b1; m_fetched = 0; m_squashed = 0;
    end else if (rv) begin
      m_squashed += int'(m_slot_v) + m_buf.size() + int'(ack);
      if (m_buf.size() != 0) m_pc = rpc;
      else if (ack) begin m_pc = rpc; m_discard = 1'b0; end
      else begin m_discard = 1'b1; m_target = rpc; end
      m_buf.delete();
      m_slot_v = 1'b0;
    end else if (m_buf.size() != 0) begin
      if (!st) begin m_slot = m_buf.pop_front(); m_slot_v = 1'b1; m_fetched++; end
    end else if (m_discard) begin
      if (ack) begin m_pc = m_target; m_discard = 1'b0; m_squashed++; end
    end else if (ack) begin
      if (take) begin m_slot = '{rdata, m_pc + 32'd4}; m_slot_v = 1'b1; m_fetched++; end
      else m_buf.push_back('{rdata, m_pc + 32'd4});
      m_pc = m_pc + 32'd4;
    end else if (take) begin
      m_slot_v = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 5))
      0: return 32'h0000_3100;
      1: return 32'h0000_3200;
      2: return 32'h0000_3300;
      3: return 32'hFFFF_FFF8;
      default: return {16'h0, $urandom_range(0, 16'hFFFF)} & 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin
    int wait_cnt;
    int max_lat;
    int p_stall;
    int p_redir;
    logic rst_i, rv_i, st_i, ack_i;
    logic [31:0] rpc_i, rd_i;

    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    im_ack = 1'b0; im_rdata = '0;
    m_known = 1'b0; m_fresh = 1'b0; m_slot_v = 1'b0; m_pc = '0;
    m_discard = 1'b0; m_target = '0; m_slot = '0; m_fetched = 0; m_squashed = 0;
    wait_cnt = 0;

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge clk);
      if (m_known) begin
        check_eq("if_valid", 32'(if_valid), 32'(m_slot_v));
        check_eq("im_req", 32'(im_req), 32'(exp_req()));
        if (exp_req()) check_eq("im_addr", im_addr, m_pc);
        if (m_slot_v || m_fresh) begin
          check_eq("if_instr", if_instr, m_fresh ? 32'h0 : m_slot.instr);
          check_eq("if_pc4", if_pc4, m_fresh ? 32'h0 : m_slot.pc4);
        end
`ifdef FETCH_PERF_EN
        check_eq("perf_fetched", perf_fetched, 32'(m_fetched));
        check_eq("perf_squashed", perf_squashed, 32'(m_squashed));
`endif
      end

      // phase 0: zero-latency streaming; later phases mix stalls, latency, redirects
      if (cyc < 200)       begin max_lat = 0; p_stall = 0;  p_redir = 0;  end
      else if (cyc < 1500) begin max_lat = 0; p_stall = 40; p_redir = 8;  end
      else                 begin max_lat = 3; p_stall = 35; p_redir = 12; end

      rst_i = (cyc < 2) || ($urandom_range(0, 299) == 0);
      st_i  = ($urandom_range(0, 99) < p_stall);
      rv_i  = ($urandom_range(0, 99) < p_redir);
      rpc_i = pick_target();
      rd_i  = $urandom;
      if (exp_req()) ack_i = (wait_cnt == 0);
      else           ack_i = 1'($urandom_range(0, 1));

      reset = rst_i; redirect_valid = rv_i; redirect_pc = rpc_i;
      stall = st_i; im_ack = ack_i; im_rdata = rd_i;

      if (rst_i || (exp_req() && ack_i)) wait_cnt = $urandom_range(0, max_lat);
      else if (exp_req()) wait_cnt--;
      model_step(rst_i, rv_i, rpc_i, st_i, ack_i, rd_i);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
